lfsr_56_checker: RTL and testbench
==================================

# lfsr_56_checker

Receive-side checker for the 56-bit pseudo-random stream produced by the team's 56-bit LFSR generator. It self-synchronises to an incoming stream of 56-bit LFSR state words, predicts each following word, and reports lock status, per-word mismatch pulses and a saturating error count. It sits downstream of any path that carries generator output, such as a memory, FIFO or clock-domain link, and qualifies that path in the LBM datapath bring-up.

## Interface
- LOCK_COUNT, 8: consecutive matching words needed in VERIFY to declare lock (≥1).
- UNLOCK_COUNT, 4: consecutive mismatching words in LOCK that force loss of sync (≥1).
- ERR_W, 16: width of err_count.
- Clk  input  1  clock; all logic on posedge.
- Reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_word is sampled this cycle.
- in_word  input  56  received LFSR state word.
- clear_errs  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCK.
- err_pulse  output  1  one-cycle pulse per mismatching word in LOCK.
- sync_loss  output  1  one-cycle pulse on the LOCK→HUNT transition.
- err_count  output  ERR_W  saturating count of mismatching words in LOCK.

## Operation
- Next-state function: next(d) = {fb, d[55:1]}, where fb = ~(d[22]^d[21]^d[1]^d[0]). This is bit-exact with the generator.
- Lockup word: all-ones (56'hFF_FFFF_FFFF_FFFF) maps to itself and is never a valid seed.
- Internal state: expected[55:0], match_cnt, bad_cnt, FSM {HUNT, VERIFY, LOCK}.
- Cycles with in_valid=0 change nothing. All transitions below occur only on in_valid=1.
- HUNT:
  - in_word == all-ones: stay in HUNT.
  - Otherwise: expected ← next(in_word), match_cnt ← 0, go to VERIFY.
- VERIFY:
  - Match (in_word == expected): expected ← next(in_word), match_cnt+1. When match_cnt+1 == LOCK_COUNT, go to LOCK with bad_cnt ← 0.
  - Mismatch: reseed with expected ← next(in_word) and match_cnt ← 0, stay in VERIFY. A mismatching all-ones word returns to HUNT instead.
- LOCK (flywheel):
  - expected ← next(expected) regardless of the compare result, so a corrupted word does not corrupt the prediction.
  - Match: bad_cnt ← 0.
  - Mismatch: err_pulse, err_count+1 (saturating at 2^ERR_W−1), bad_cnt+1.
  - When bad_cnt+1 == UNLOCK_COUNT: go to HUNT and pulse sync_loss, in the same cycle as the last err_pulse.
- Mismatches in HUNT and VERIFY never touch err_count or err_pulse.
- clear_errs: err_count ← 0. It has priority over a coincident increment, so the result is 0. err_pulse still fires.
- Reset values: FSM=HUNT, expected=0, match_cnt=0, bad_cnt=0, locked=0, err_pulse=0, sync_loss=0, err_count=0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Checking restarts from HUNT on the first in_valid after release.

## Timing
- All outputs are registered. Each responds in the cycle after the Clk edge that samples the causing in_valid word.
- With back-to-back valid words, locked rises one cycle after the (LOCK_COUNT+1)-th word: 1 seed plus LOCK_COUNT matches.
- locked falls, and sync_loss pulses, one cycle after the UNLOCK_COUNT-th consecutive bad word.
- Throughput: one word per cycle with no stall. There is no back-pressure output.
- Reset deassertion is synchronised externally. No input is sampled in the first edge after release.

## Structure
- Package lfsr_56_pkg:
  - LFSR_W = 56 and ALL_ONES constant.
  - Function lfsr_56_next(d) implementing the next-state function above. The generator is refactored to use the same function.
  - Checker state enum {HUNT, VERIFY, LOCK}.
- No sub-module. Single always_ff for state and counters plus always_comb for the compare. Counter widths are $clog2(LOCK_COUNT+1) and $clog2(UNLOCK_COUNT+1).

## Test plan
- **Lock acquisition:** generator seeded 56'h1 (stream 56'h1, 56'h0, 56'h80_0000_0000_0000, …) feeds the checker continuously → locked=1 one cycle after the 9th word; err_count=0.
- **Single error, flywheel:** in LOCK, flip bit 0 of one word → one err_pulse, err_count=1, locked stays 1; following correct words give no further pulses.
- **Loss of sync:** in LOCK, corrupt 4 consecutive words → err_count=4, sync_loss and the 4th err_pulse coincide, locked=0 next cycle; relock after 9 more good words.
- **Lockup word and gaps:** in HUNT, feed all-ones words → FSM stays HUNT. Then feed a valid stream with in_valid randomly low ~50% → lock after exactly 9 valid words.
- **Saturation and clear (ERR_W=4):** in LOCK, alternate good and bad words for 20 bad words → err_count holds at 15. clear_errs coincident with a bad word → err_pulse=1, err_count=0.
- **Reset mid-VERIFY:** assert Reset after 5 good words → all outputs 0 at once; after release, 9 fresh words are required to lock.

Source files
------------

// File: rtl/lfsr_56_pkg.sv
// Shared definitions for the 56-bit LFSR generator and checker.
// lfsr_56_next is the single source of truth for the stream.
package lfsr_56_pkg;

  localparam int unsigned LFSR_W = 56;
  localparam logic [LFSR_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLock
  } chk_state_e;

  // XNOR feedback, so all-ones is the lockup word and all-zeros is legal.
  function automatic logic [LFSR_W-1:0] lfsr_56_next(input logic [LFSR_W-1:0] d);
    logic fb;
    fb = ~(d[22] ^ d[21] ^ d[1] ^ d[0]);
    return {fb, d[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_56_checker.sv
// Self-synchronising checker for a 56-bit LFSR stream: hunts for a seed, verifies
// LOCK_COUNT predictions, then flywheels and counts mismatches until sync is lost.
module lfsr_56_checker
  import lfsr_56_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned ERR_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid_i,
  input  logic [LFSR_W-1:0] in_word_i,
  input  logic              clear_errs_i,
  output logic              locked_o,
  output logic              err_pulse_o,
  output logic              sync_loss_o,
  output logic [ERR_W-1:0]  err_count_o
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW   = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
  localparam logic [BadW-1:0]   BadLast   = BadW'(UNLOCK_COUNT - 1);

  chk_state_e        state_q;
  logic [LFSR_W-1:0] expected_q;
  logic [MatchW-1:0] match_cnt_q;
  logic [BadW-1:0]   bad_cnt_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic              sync_loss_q;
  logic [ERR_W-1:0]  err_count_q;

  logic              word_match;
  logic              word_lockup;
  logic              err_sat;
  logic [LFSR_W-1:0] in_next;
  logic [LFSR_W-1:0] exp_next;

  always_comb begin
    word_match  = (in_word_i == expected_q);
    word_lockup = (in_word_i == ALL_ONES);
    err_sat     = &err_count_q;
    in_next     = lfsr_56_next(in_word_i);
    exp_next    = lfsr_56_next(expected_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StHunt;
      expected_q  <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      if (in_valid_i) begin
        unique case (state_q)
          StHunt: begin
            if (!word_lockup) begin
              expected_q  <= in_next;
              match_cnt_q <= '0;
              state_q     <= StVerify;
            end
          end
          StVerify: begin
            if (word_match) begin
              expected_q  <= in_next;
              match_cnt_q <= match_cnt_q + 1'b1;
              if (match_cnt_q == MatchLast) begin
                state_q   <= StLock;
                locked_q  <= 1'b1;
                bad_cnt_q <= '0;
              end
            end else if (word_lockup) begin
              match_cnt_q <= '0;
              state_q     <= StHunt;
            end else begin
              expected_q  <= in_next;
              match_cnt_q <= '0;
            end
          end
          StLock: begin
            // Flywheel: the prediction never follows a corrupted input word.
            expected_q <= exp_next;
            if (word_match) begin
              bad_cnt_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              bad_cnt_q   <= bad_cnt_q + 1'b1;
              if (!err_sat) err_count_q <= err_count_q + 1'b1;
              if (bad_cnt_q == BadLast) begin
                state_q     <= StHunt;
                locked_q    <= 1'b0;
                sync_loss_q <= 1'b1;
              end
            end
          end
          default: state_q <= StHunt;
        endcase
      end
      if (clear_errs_i) err_count_q <= '0;
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign sync_loss_o = sync_loss_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_lfsr_56_checker.sv
// Scenario bench for lfsr_56_checker: expected outputs are queued as each word is
// driven and popped one cycle later when the registered outputs respond.
module tb_lfsr_56_checker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [55:0] in_word;
  logic        clear_errs;
  logic        locked, err_pulse, sync_loss;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, sync_loss4;
  logic [3:0]  err_count4;

  always #5 Clk = ~Clk;

  lfsr_56_checker dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .in_valid_i   (in_valid),
    .in_word_i    (in_word),
    .clear_errs_i (clear_errs),
    .locked_o     (locked),
    .err_pulse_o  (err_pulse),
    .sync_loss_o  (sync_loss),
    .err_count_o  (err_count)
  );

  lfsr_56_checker #(.ERR_W(4)) dut4 (
    .Clk          (Clk),
    .Reset        (Reset),
    .in_valid_i   (in_valid),
    .in_word_i    (in_word),
    .clear_errs_i (clear_errs),
    .locked_o     (locked4),
    .err_pulse_o  (err_pulse4),
    .sync_loss_o  (sync_loss4),
    .err_count_o  (err_count4)
  );

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic        sl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  exp_t        got;
  int          total = 0;
  int          bad   = 0;
  logic [55:0] g;

  function automatic logic [55:0] ref_next(input logic [55:0] d);
    return {~(d[22] ^ d[21] ^ d[1] ^ d[0]), d[55:1]};
  endfunction

  task automatic drive(input logic v, input logic [55:0] w, input logic clr);
    in_valid   = v;
    in_word    = w;
    clear_errs = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset      = 1'b0;
    in_valid   = 1'b0;
    clear_errs = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    drive(1'b0, 56'h0, 1'b0);
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;
    clear_errs = 1'b0;
    #3;
    exp_q.push_back('0);
    e   = exp_q.pop_front();
    got = {locked, err_pulse, sync_loss, err_count};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset: got=%h need=%h", got, e);
    end
    exp_q.push_back('0);
    e   = exp_q.pop_front();
    got = {locked4, err_pulse4, sync_loss4, 12'd0, err_count4};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset_w4: got=%h need=%h", got, e);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    drive(1'b0, 56'h0, 1'b0);
  endtask

  task automatic test_lock();
    g = 56'h1;
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(exp_t'{lk: (i == 9), ep: 1'b0, sl: 1'b0, cnt: 16'd0});
      drive(1'b1, g, 1'b0);
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL lock word %0d: got=%h need=%h", i, got, e);
      end
    end
  endtask

  task automatic test_flywheel();
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(exp_t'{lk: 1'b1, ep: (k == 0), sl: 1'b0, cnt: 16'd1});
      drive(1'b1, (k == 0) ? (g ^ 56'h1) : g, 1'b0);
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL flywheel word %0d: got=%h need=%h", k, got, e);
      end
    end
  endtask

  task automatic test_sync_loss();
    // Good word with a clear, then four bad words, then relock.
    for (int k = 0; k < 14; k++) begin
      if (k == 0)
        exp_q.push_back(exp_t'{lk: 1'b1, ep: 1'b0, sl: 1'b0, cnt: 16'd0});
      else if (k <= 4)
        exp_q.push_back(exp_t'{lk: (k < 4), ep: 1'b1, sl: (k == 4), cnt: 16'(k)});
      else
        exp_q.push_back(exp_t'{lk: (k == 13), ep: 1'b0, sl: 1'b0, cnt: 16'd4});
      drive(1'b1, (k >= 1 && k <= 4) ? (g ^ 56'h1) : g, (k == 0));
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL sync_loss word %0d: got=%h need=%h", k, got, e);
      end
    end
  endtask

  task automatic test_verify_mismatch();
    apply_reset();
    // 4 good, 1 bad (reseeds), then the next good word reseeds again: lock on 9th good.
    for (int k = 0; k < 14; k++) begin
      exp_q.push_back(exp_t'{lk: (k == 13), ep: 1'b0, sl: 1'b0, cnt: 16'd0});
      drive(1'b1, (k == 4) ? (g ^ (56'h1 << 30)) : g, 1'b0);
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL verify_mismatch word %0d: got=%h need=%h", k, got, e);
      end
    end
  endtask

  task automatic test_gaps();
    int   n;
    int   cyc;
    logic v;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('0);
      drive(1'b1, 56'hFF_FFFF_FFFF_FFFF, 1'b0);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL lockup word %0d: got=%h need=%h", k, got, e);
      end
    end
    n   = 0;
    cyc = 0;
    while (n < 9 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      if (v) n++;
      exp_q.push_back(exp_t'{lk: (n == 9), ep: 1'b0, sl: 1'b0, cnt: 16'd0});
      drive(v, v ? g : {24'($urandom), 32'($urandom)}, 1'b0);
      if (v) g = ref_next(g);
      cyc++;
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL gaps cycle %0d valid %0d: got=%h need=%h", cyc, n, got, e);
      end
    end
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL gaps budget: valid words=%0d need=9", n);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(exp_t'{lk: (i == 9), ep: 1'b0, sl: 1'b0, cnt: 16'd0});
      drive(1'b1, g, 1'b0);
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked4, err_pulse4, sync_loss4, 12'd0, err_count4};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL sat_lock word %0d: got=%h need=%h", i, got, e);
      end
    end
    for (int j = 0; j < 41; j++) begin
      // Even j: good word; odd j: bad word; j=40 is a bad word with clear.
      if (j == 40)
        exp_q.push_back(exp_t'{lk: 1'b1, ep: 1'b1, sl: 1'b0, cnt: 16'd0});
      else
        exp_q.push_back(exp_t'{lk: 1'b1, ep: j[0], sl: 1'b0,
                               cnt: 16'(((j + 1) / 2 > 15) ? 15 : (j + 1) / 2)});
      drive(1'b1, (j % 2 == 1 || j == 40) ? (g ^ 56'h1) : g, (j == 40));
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked4, err_pulse4, sync_loss4, 12'd0, err_count4};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL saturate step %0d: got=%h need=%h", j, got, e);
      end
      if (j == 39) begin
        total++;
        if (err_count !== 16'd20) begin
          bad++;
          $display("FAIL wide_count: got=%0d need=20", err_count);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(exp_t'{lk: (i >= 9), ep: (i == 10), sl: 1'b0, cnt: 16'(i == 10)});
      drive(1'b1, (i == 10) ? (g ^ 56'h1) : g, 1'b0);
      g   = ref_next(g);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL pre_reset word %0d: got=%h need=%h", i, got, e);
      end
    end
    for (int r = 0; r < 2; r++) begin
      #1 Reset = 1'b0;
      #1;
      exp_q.push_back('0);
      e   = exp_q.pop_front();
      got = {locked, err_pulse, sync_loss, err_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL async_reset %0d: got=%h need=%h", r, got, e);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      drive(1'b0, g, 1'b0);
      // First pass: 5 good words (mid-VERIFY); second pass: 9 words to lock.
      for (int i = 1; i <= ((r == 0) ? 5 : 9); i++) begin
        exp_q.push_back(exp_t'{lk: (r == 1 && i == 9), ep: 1'b0, sl: 1'b0, cnt: 16'd0});
        drive(1'b1, g, 1'b0);
        g   = ref_next(g);
        e   = exp_q.pop_front();
        got = {locked, err_pulse, sync_loss, err_count};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL post_reset %0d word %0d: got=%h need=%h", r, i, got, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_flywheel();
    test_sync_loss();
    test_verify_mismatch();
    test_gaps();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
